// File: rtl/prestore_capture_if.sv
// Sample-in / replay-out bundle for prestore_capture.
// The slave modport is the capture block's view; master is the driver/consumer side.
interface prestore_capture_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              arm;
    logic [ADDR_W:0]   len_words;
    logic              time_pulse;
    logic              valid;
    logic              I_sum_sig;
    logic              I_sum_mag;
    logic              Q_sum_sig;
    logic              Q_sum_mag;
    logic              busy;
    logic              done;
    logic              rd_start;
    logic              rd_valid;
    logic              rd_ready;
    logic [31:0]       rd_data;
    logic              rd_last;
    logic [31:0]       cap_time;

    modport slave (
        input  arm, len_words, time_pulse, valid,
        input  I_sum_sig, I_sum_mag, Q_sum_sig, Q_sum_mag,
        input  rd_start, rd_ready,
        output busy, done, rd_valid, rd_data, rd_last, cap_time
    );

    modport master (
        output arm, len_words, time_pulse, valid,
        output I_sum_sig, I_sum_mag, Q_sum_sig, Q_sum_mag,
        output rd_start, rd_ready,
        input  busy, done, rd_valid, rd_data, rd_last, cap_time
    );
endinterface

// File: rtl/prestore_capture.sv
// Time-aligned capture of the 2-bit I/Q stream into RAM, replayed as a valid/ready word stream.
// Optional sample timestamp: define PRESTORE_CAPTURE_TIMESTAMP_EN.
module prestore_capture #(
    parameter int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned ADDR_W = $clog2(DEPTH_WORDS)
) (
    input logic              clk,
    input logic              clr,
    prestore_capture_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StArmed, StCapture, StFull} state_e;

    localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(DEPTH_WORDS);

    state_e            state_q;
    logic [ADDR_W:0]   len_q;
    logic              pending_q;
    logic [31:0]       pack_q;
    logic [2:0]        nib_cnt_q;
    logic [ADDR_W-1:0] word_ptr_q;
    logic              wr_en_q;
    logic              wr_last_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [31:0]       wr_data_q;
    logic              busy_q;
    logic              done_q;

    logic [31:0]       mem [DEPTH_WORDS];
    logic [3:0]        nib;
    logic [31:0]       pack_next;
    logic [ADDR_W:0]   len_eff;
    logic              start_hit;

    assign nib       = {bus.Q_sum_mag, bus.Q_sum_sig, bus.I_sum_mag, bus.I_sum_sig};
    assign len_eff   = (bus.len_words == '0 || bus.len_words > DepthW) ? DepthW : bus.len_words;
    assign start_hit = bus.valid && (pending_q || bus.time_pulse);

    always_comb begin
        pack_next = pack_q;
        pack_next[{nib_cnt_q, 2'b00} +: 4] = nib;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= StIdle;
            len_q      <= DepthW;
            pending_q  <= 1'b0;
            pack_q     <= '0;
            nib_cnt_q  <= '0;
            word_ptr_q <= '0;
            wr_en_q    <= 1'b0;
            wr_last_q  <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            busy_q  <= (state_q == StArmed) || (state_q == StCapture);
            done_q  <= state_q == StFull;
            if (bus.arm) begin
                state_q    <= StArmed;
                len_q      <= len_eff;
                pending_q  <= 1'b0;
                nib_cnt_q  <= '0;
                word_ptr_q <= '0;
                wr_last_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle, StFull: ;
                    StArmed: begin
                        if (start_hit) begin
                            state_q   <= StCapture;
                            pack_q    <= pack_next;
                            nib_cnt_q <= 3'd1;
                            pending_q <= 1'b0;
                        end else if (bus.time_pulse) begin
                            pending_q <= 1'b1;
                        end
                    end
                    StCapture: begin
                        if (wr_en_q && wr_last_q) state_q <= StFull;
                        // Completed word is parked in wr_data_q so packing never stalls.
                        if (bus.valid) begin
                            pack_q    <= pack_next;
                            nib_cnt_q <= nib_cnt_q + 3'd1;
                            if (nib_cnt_q == 3'd7) begin
                                wr_en_q    <= 1'b1;
                                wr_addr_q  <= word_ptr_q;
                                wr_data_q  <= pack_next;
                                wr_last_q  <= {1'b0, word_ptr_q} == len_q - (ADDR_W + 1)'(1);
                                word_ptr_q <= word_ptr_q + ADDR_W'(1);
                            end
                        end
                    end
                endcase
            end
        end
    end

    // Replay: RAM output register plus one skid entry form a 2-deep in-order buffer.
    logic              rd_active_q;
    logic [ADDR_W:0]   fetch_ptr_q;
    logic [31:0]       ram_dout_q;
    logic              ram_vld_q;
    logic              ram_last_q;
    logic [31:0]       skid_q;
    logic              skid_vld_q;
    logic              skid_last_q;
    logic              rd_valid_int;
    logic              rd_start_ok;
    logic              pop;
    logic              rem_skid;
    logic              rem_ram;
    logic              issue;

    assign rd_valid_int = ram_vld_q || skid_vld_q;
    assign rd_start_ok  = bus.rd_start && (state_q == StFull) && !bus.arm;
    assign pop          = rd_valid_int && bus.rd_ready;

    always_comb begin
        rem_skid = skid_vld_q && !pop;
        rem_ram  = ram_vld_q && !(pop && !skid_vld_q);
        issue    = rd_active_q && !rd_start_ok && !bus.arm && (fetch_ptr_q < len_q) &&
                   !(rem_skid && rem_ram);
    end

    always_ff @(posedge clk) begin
        if (wr_en_q) mem[wr_addr_q] <= wr_data_q;
        if (issue) ram_dout_q <= mem[fetch_ptr_q[ADDR_W-1:0]];
    end

    always_ff @(posedge clk) begin
        if (clr || bus.arm) begin
            rd_active_q <= 1'b0;
            fetch_ptr_q <= '0;
            ram_vld_q   <= 1'b0;
            ram_last_q  <= 1'b0;
            skid_q      <= '0;
            skid_vld_q  <= 1'b0;
            skid_last_q <= 1'b0;
        end else if (rd_start_ok) begin
            rd_active_q <= 1'b1;
            fetch_ptr_q <= '0;
            ram_vld_q   <= 1'b0;
            skid_vld_q  <= 1'b0;
        end else begin
            skid_vld_q <= rem_skid || (rem_ram && issue);
            if (!rem_skid && rem_ram && issue) begin
                skid_q      <= ram_dout_q;
                skid_last_q <= ram_last_q;
            end
            ram_vld_q <= issue || rem_ram;
            if (issue) begin
                fetch_ptr_q <= fetch_ptr_q + (ADDR_W + 1)'(1);
                ram_last_q  <= fetch_ptr_q == len_q - (ADDR_W + 1)'(1);
            end
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rd_valid = rd_valid_int;
    assign bus.rd_data  = skid_vld_q ? skid_q : (ram_vld_q ? ram_dout_q : '0);
    assign bus.rd_last  = skid_vld_q ? skid_last_q : (ram_vld_q && ram_last_q);

`ifdef PRESTORE_CAPTURE_TIMESTAMP_EN
    logic [31:0] ts_cnt_q;
    logic [31:0] cap_time_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            ts_cnt_q   <= '0;
            cap_time_q <= '0;
        end else begin
            if (bus.valid) ts_cnt_q <= ts_cnt_q + 32'd1;
            if (state_q == StArmed && !bus.arm && start_hit) cap_time_q <= ts_cnt_q;
        end
    end

    assign bus.cap_time = cap_time_q;
`else
    assign bus.cap_time = '0;
`endif
endmodule

// File: tb/tb_prestore_capture.sv
// Randomized bench for prestore_capture against a nibble-queue reference model.
module tb_prestore_capture;
    localparam int unsigned Depth = 4;
    localparam int unsigned AddrW = 2;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    prestore_capture_if #(.ADDR_W(AddrW)) bus ();
    prestore_capture #(.DEPTH_WORDS(Depth)) dut (.clk(clk), .clr(clr), .bus(bus));

    int          n_checks = 0;
    int          n_bad    = 0;
    int          ts_cnt   = 0;   // valid samples driven since clr
    int          exp_cap  = 0;
    int          exp_len  = 0;
    logic [31:0] exp_words [Depth];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input bit tp, input logic [3:0] nib);
        bus.valid      = v;
        bus.time_pulse = tp;
        {bus.Q_sum_mag, bus.Q_sum_sig, bus.I_sum_mag, bus.I_sum_sig} = nib;
        tick();
        if (v) ts_cnt++;
        bus.valid      = 1'b0;
        bus.time_pulse = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        tick();
        clr     = 1'b0;
        ts_cnt  = 0;
        exp_cap = 0;
    endtask

    task automatic do_arm(input logic [2:0] len_in);
        bus.len_words = len_in;
        bus.arm       = 1'b1;
        tick();
        bus.arm = 1'b0;
        exp_len = (len_in == 0 || int'(len_in) > Depth) ? Depth : int'(len_in);
    endtask

    task automatic capture(input logic [2:0] len_in, input int n_pre, input bit pulse_on_valid,
                           input bit seq_nib, input int v_pct, input int abort_after);
        logic [3:0] nibs [$];
        logic [3:0] nb;
        int         need;
        int         t;
        do_arm(len_in);
        need = 8 * exp_len;
        for (int i = 0; i < n_pre; i++)
            drive($urandom_range(99) < v_pct, 1'b0, 4'($urandom));
        if (!pulse_on_valid) begin
            drive(1'b0, 1'b1, 4'h0);
            repeat ($urandom_range(3)) drive(1'b0, 1'b0, 4'h0);
        end
        exp_cap = ts_cnt;
        nb = seq_nib ? 4'h0 : 4'($urandom);
        drive(1'b1, pulse_on_valid, nb);
        nibs.push_back(nb);
        check_val("busy_cap", 32'(bus.busy), 32'd1);
        while (nibs.size() < need) begin
            if (abort_after > 0 && nibs.size() == abort_after) return;
            if ($urandom_range(99) < v_pct) begin
                nb = seq_nib ? 4'(nibs.size()) : 4'($urandom);
                drive(1'b1, 1'($urandom), nb);
                nibs.push_back(nb);
            end else begin
                drive(1'b0, 1'($urandom), 4'($urandom));
            end
        end
        check_val("done_early", 32'(bus.done), 32'd0);
        t = 0;
        while (!bus.done && t < 10) begin
            drive(1'($urandom), 1'($urandom), 4'($urandom));
            t++;
        end
        check_val("done", 32'(bus.done), 32'd1);
        check_val("busy_full", 32'(bus.busy), 32'd0);
`ifdef PRESTORE_CAPTURE_TIMESTAMP_EN
        check_val("cap_time", bus.cap_time, 32'(exp_cap));
`else
        check_val("cap_time", bus.cap_time, 32'd0);
`endif
        for (int w = 0; w < exp_len; w++) begin
            exp_words[w] = '0;
            for (int k = 0; k < 8; k++)
                exp_words[w] = exp_words[w] | (32'(nibs[8 * w + k]) << (4 * k));
        end
    endtask

    task automatic replay(input int ready_pct, input int restart_at);
        int          idx = 0;
        int          cyc = 0;
        int          first = -1;
        bit          restarted = 1'b0;
        bit          held = 1'b0;
        logic [31:0] hold_data = '0;
        logic        hold_last = 1'b0;
        bus.rd_start = 1'b1;
        bus.rd_ready = 1'b0;
        tick();
        bus.rd_start = 1'b0;
        while (idx < exp_len && cyc < 200) begin
            if (held) begin
                check_val("hold_valid", 32'(bus.rd_valid), 32'd1);
                check_val("hold_data", bus.rd_data, hold_data);
                check_val("hold_last", 32'(bus.rd_last), 32'(hold_last));
                held = 1'b0;
            end
            if (bus.rd_valid && first < 0) begin
                first = cyc;
                check_val("rd_latency", 32'(cyc), 32'd1);
            end
            if (!restarted && idx == restart_at) begin
                restarted    = 1'b1;
                bus.rd_ready = 1'b0;
                bus.rd_start = 1'b1;
                tick();
                bus.rd_start = 1'b0;
                idx   = 0;
                cyc   = 0;
                first = -1;
                continue;
            end
            bus.rd_ready = $urandom_range(99) < ready_pct;
            if (bus.rd_valid && bus.rd_ready) begin
                check_val("rd_data", bus.rd_data, exp_words[idx]);
                check_val("rd_last", 32'(bus.rd_last), 32'(idx == exp_len - 1));
                idx++;
            end else if (bus.rd_valid) begin
                held      = 1'b1;
                hold_data = bus.rd_data;
                hold_last = bus.rd_last;
            end
            tick();
            cyc++;
        end
        bus.rd_ready = 1'b0;
        check_val("rd_count", 32'(idx), 32'(exp_len));
        check_val("rd_valid_after", 32'(bus.rd_valid), 32'd0);
        check_val("done_replay", 32'(bus.done), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len_r;
        bus.arm = 1'b0;
        bus.len_words = '0;
        bus.time_pulse = 1'b0;
        bus.valid = 1'b0;
        {bus.Q_sum_mag, bus.Q_sum_sig, bus.I_sum_mag, bus.I_sum_sig} = 4'h0;
        bus.rd_start = 1'b0;
        bus.rd_ready = 1'b0;
        do_clr();
        check_val("rst_busy", 32'(bus.busy), 32'd0);
        check_val("rst_done", 32'(bus.done), 32'd0);
        check_val("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        check_val("rst_rd_data", bus.rd_data, 32'd0);
        check_val("rst_rd_last", 32'(bus.rd_last), 32'd0);
        check_val("rst_cap_time", bus.cap_time, 32'd0);

        // Two words of sequential nibbles, pulse coincident with sample 0.
        capture(3'd2, 0, 1'b1, 1'b1, 100, 0);
        replay(100, -1);
        // Pre-pulse samples discarded, pending pulse honoured on a later valid.
        capture(3'd1, 5, 1'b0, 1'b0, 100, 0);
        replay(100, -1);
        // Zero length means full depth, continuous valid.
        capture(3'd0, 0, 1'b1, 1'b0, 100, 0);
        replay(100, -1);
        replay(50, 2);

        // Arm during a stalled replay drops rd_valid on the next cycle.
        bus.rd_start = 1'b1;
        tick();
        bus.rd_start = 1'b0;
        tick();
        tick();
        check_val("rp_pre_arm", 32'(bus.rd_valid), 32'd1);
        bus.len_words = 3'd2;
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        check_val("rp_arm_drop", 32'(bus.rd_valid), 32'd0);

        // Abort after 11 samples; rd_start outside FULL is ignored.
        capture(3'd3, 2, 1'b1, 1'b0, 100, 11);
        drive(1'b0, 1'b0, 4'h0);
        check_val("abort_busy", 32'(bus.busy), 32'd1);
        check_val("abort_done", 32'(bus.done), 32'd0);
        bus.rd_start = 1'b1;
        tick();
        bus.rd_start = 1'b0;
        tick();
        tick();
        check_val("rd_start_ignored", 32'(bus.rd_valid), 32'd0);
        capture(3'd2, 0, 1'b0, 1'b0, 80, 0);
        replay(100, -1);

        for (int it = 0; it < 6; it++) begin
            capture(3'($urandom), int'($urandom_range(6)), 1'($urandom), 1'b0,
                    int'($urandom_range(100, 40)), 0);
            len_r = (exp_len > 1 && $urandom_range(1) == 1) ?
                    int'($urandom_range(exp_len - 1, 1)) : -1;
            replay(int'($urandom_range(100, 30)), len_r);
        end

        // Timestamp: 100 valid samples precede sample 0 after clr.
        do_clr();
        capture(3'd1, 100, 1'b1, 1'b0, 100, 0);
        replay(100, -1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule

// File: doc/prestore_capture.md
Name: prestore_capture

Overview:
- Receive-side consumer of the prestore decimated 2-bit I/Q stream (sig/mag per component, valid strobe, time pulse).
- Arms on request and aligns the capture start to a time pulse.
- Packs samples 8-per-32-bit word into an internal dual-port RAM.
- Replays the captured record word-by-word over a valid/ready stream to the downstream acquisition correlator.

Parameters:
- DEPTH_WORDS, 1024, capture RAM depth in 32-bit words; power of 2, >=2.
- ADDR_W, $clog2(DEPTH_WORDS), RAM address width (derived, not overridden).

Ports:
- clk  in  1  system clock
- clr  in  1  synchronous active-high reset
- arm  in  1  pulse: start or restart capture
- len_words  in  ADDR_W+1  record length in words, latched on arm
- time_pulse  in  1  epoch marker from prestore
- valid  in  1  sample strobe
- I_sum_sig, I_sum_mag, Q_sum_sig, Q_sum_mag  in  1 each  sample bits
- busy  out  1  high in ARMED or CAPTURE
- done  out  1  high in FULL
- rd_start  in  1  pulse: begin replay
- rd_valid  out  1  replay data valid
- rd_ready  in  1  downstream accept
- rd_data  out  32  packed word
- rd_last  out  1  marks final word of record
- cap_time  out  32  sample index of capture start (see Optional Feature)

Behaviour:
- Reset (clr=1, synchronous): state IDLE; all outputs 0; pack/word/read pointers 0; pending-pulse flag 0. RAM contents are not cleared.
- Length latch at arm:
  - L = len_words.
  - L=0 -> DEPTH_WORDS.
  - L>DEPTH_WORDS -> DEPTH_WORDS.
- Capture FSM:
  - IDLE: arm -> ARMED.
  - ARMED: time_pulse sets pending.
    - First cycle with valid=1 and (pending or time_pulse) -> that sample is sample 0; state -> CAPTURE.
    - valid samples before that are discarded.
  - CAPTURE: each valid packs one nibble {Q_mag,Q_sig,I_mag,I_sig} into bits [4k+3:4k], k=0..7, sample 0 in the LSBs.
    - On the 8th nibble, the completed word is written to RAM[word_ptr] in the following cycle, and word_ptr increments.
    - After word L-1 is written -> FULL.
    - time_pulse is ignored in CAPTURE.
    - Samples arriving in the write cycle are packed without loss; valid may be high every cycle.
  - FULL: done=1, holds until arm or clr.
  - arm in any state (including mid-capture or mid-replay): aborts everything, clears pointers and pending, relatches L, next state ARMED. rd_valid drops the next cycle.
- Replay (legal only in FULL; rd_start elsewhere is ignored):
  - rd_start resets read pointer to 0. RAM read latency is 1, so the first rd_valid is 2 cycles after rd_start.
  - AXI-stream rules: rd_data/rd_last stable while rd_valid & !rd_ready; transfer on rd_valid & rd_ready.
  - Sustains 1 word/cycle with rd_ready tied high; uses a 1-entry skid/prefetch.
  - rd_last=1 on word L-1. After that transfer rd_valid=0; done stays 1.
  - rd_start mid-replay restarts from word 0. Replay may be repeated any number of times.
- busy/done are registered; they change the cycle after the state transition.

Optional Feature:
- Macro: PRESTORE_CAPTURE_TIMESTAMP_EN.
- Defined:
  - A 32-bit free-running counter increments on every valid=1 since clr and wraps at 2^32.
  - cap_time latches the counter value of sample 0 when entering CAPTURE; it holds until the next such event.
  - cap_time is 0 after clr.
- Undefined: counter not built; cap_time constant 0.

Test Plan:
- clr, arm with len_words=2, time_pulse on a cycle with valid=1, then 15 further valid samples with nibble pattern 0x0..0xF -> RAM word0=0x76543210, word1=0xFEDCBA98; done=1; rd_start with rd_ready=1 -> rd_data 0x76543210 then 0xFEDCBA98, rd_last on the 2nd, rd_valid low after.
- arm, 5 valid samples with no time_pulse, then time_pulse with valid=0, then valid sample 0xA -> 0xA is the LSB nibble of word0; the earlier 5 samples are absent.
- len_words=0 with DEPTH_WORDS=4, continuous valid -> 32 samples captured, done after 4th word written; replay of 4 words with rd_last on word 3.
- Replay with rd_ready toggling 1,0,0,1 -> rd_data held constant while stalled; no word skipped or duplicated; rd_start during replay restarts at word0.
- arm mid-capture after 11 samples, new time_pulse -> busy stays 1, done stays 0, new record starts at word0 with the new sample 0.
- With PRESTORE_CAPTURE_TIMESTAMP_EN: 100 valid samples before sample 0 -> cap_time=100; without the macro -> cap_time=0.
